// File: rtl/glb_store_dma.sv
// Store DMA for one global-buffer tile: queues store headers, packs 16-bit CGRA words into 64-bit bank lines.
// Optional macro GLB_ST_DMA_DROP_CNT_EN adds a saturating counter of stream words dropped outside a transfer.
//
// state  | meaning
// IDLE   | waiting for a header at the FIFO head (popped only while cfg_st_dma_on)
// STREAM | packing stream words into the current line, emitting each completed line
// DONE   | one-cycle completion pulse, then back to IDLE
//
// hdr_in layout    : {valid[43], start_addr[42:21], num_words[20:0]}
// wr_packet layout : {wr_en[94], wr_strb[93:86], wr_addr[85:64], wr_data[63:0]}
module glb_store_dma #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_st_dma_on,
  input  logic                           hdr_wr_en,
  input  logic [43:0]                    hdr_in,
  output logic                           hdr_full,
  output logic [$clog2(QUEUE_DEPTH):0]   hdr_count,
  input  logic [15:0]                    stream_data_f2g,
  input  logic                           stream_data_valid_f2g,
  output logic [94:0]                    wr_packet,
  output logic                           st_dma_done_pulse
`ifdef GLB_ST_DMA_DROP_CNT_EN
  ,
  output logic [15:0]                    st_dma_drop_cnt
`endif
);

  localparam int GLB_ADDR_WIDTH      = 22;
  localparam int MAX_NUM_WORDS_WIDTH = 21;
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int CGRA_DATA_WIDTH     = 16;
  localparam int BANK_STRB_WIDTH     = BANK_DATA_WIDTH / 8;
  localparam int LINE_ADDR_WIDTH     = GLB_ADDR_WIDTH - 3;
  localparam int PTR_W               = $clog2(QUEUE_DEPTH);
  localparam int CNT_W               = PTR_W + 1;
  localparam int HDR_W               = 1 + GLB_ADDR_WIDTH + MAX_NUM_WORDS_WIDTH;

  typedef struct packed {
    logic                           valid;
    logic [GLB_ADDR_WIDTH-1:0]      start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_words;
  } dma_st_header_t;

  typedef struct packed {
    logic                       wr_en;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [HDR_W-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             push_ok;
  logic             pop;
  dma_st_header_t   head;

  logic [LINE_ADDR_WIDTH-1:0]     line_addr;
  logic [1:0]                     word_idx;
  logic [MAX_NUM_WORDS_WIDTH-1:0] remaining;
  logic [BANK_DATA_WIDTH-1:0]     acc_data, acc_data_nx, lane_data;
  logic [BANK_STRB_WIDTH-1:0]     acc_strb, acc_strb_nx, lane_strb;
  logic                           word_take;
  logic                           last_word;
  logic                           line_done;
  wr_packet_t                     pkt_q;
  logic                           unused_addr_lsb;

  assign head            = dma_st_header_t'(mem[rd_ptr]);
  assign unused_addr_lsb = head.start_addr[0];
  assign fifo_empty      = (count == '0);
  assign hdr_full        = (count == CNT_W'(QUEUE_DEPTH));
  assign hdr_count       = count;
  assign push_ok         = hdr_wr_en && !hdr_full;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= hdr_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_st_dma_on && !fifo_empty) begin
          pop = 1'b1;
          if (head.valid && head.num_words != '0) state_next = STREAM;
          else if (head.valid)                    state_next = DONE;
        end
      end
      STREAM: begin
        if (word_take && last_word) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane placement of the incoming word within the current 64-bit line.
  assign word_take   = (state == STREAM) && stream_data_valid_f2g;
  assign last_word   = (remaining == MAX_NUM_WORDS_WIDTH'(1));
  assign line_done   = (word_idx == 2'd3) || last_word;
  assign lane_data   = BANK_DATA_WIDTH'(stream_data_f2g) << {word_idx, 4'b0000};
  assign lane_strb   = BANK_STRB_WIDTH'(2'b11) << {word_idx, 1'b0};
  assign acc_data_nx = acc_data | lane_data;
  assign acc_strb_nx = acc_strb | lane_strb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_addr <= '0;
      word_idx  <= '0;
      remaining <= '0;
      acc_data  <= '0;
      acc_strb  <= '0;
      pkt_q     <= '0;
    end else begin
      pkt_q <= '0;
      if (pop && head.valid && head.num_words != '0) begin
        line_addr <= head.start_addr[GLB_ADDR_WIDTH-1:3];
        word_idx  <= head.start_addr[2:1];
        remaining <= head.num_words;
        acc_data  <= '0;
        acc_strb  <= '0;
      end else if (word_take) begin
        remaining <= remaining - 1'b1;
        if (line_done) begin
          pkt_q.wr_en   <= 1'b1;
          pkt_q.wr_strb <= acc_strb_nx;
          pkt_q.wr_addr <= {line_addr, 3'b000};
          pkt_q.wr_data <= acc_data_nx;
          acc_data      <= '0;
          acc_strb      <= '0;
          line_addr     <= line_addr + 1'b1;
          word_idx      <= '0;
        end else begin
          acc_data <= acc_data_nx;
          acc_strb <= acc_strb_nx;
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

  assign wr_packet         = pkt_q;
  assign st_dma_done_pulse = (state == DONE);

`ifdef GLB_ST_DMA_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_dma_drop_cnt <= '0;
    end else if (stream_data_valid_f2g && state != STREAM && st_dma_drop_cnt != 16'hFFFF) begin
      st_dma_drop_cnt <= st_dma_drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_glb_store_dma.sv
// Directed bench for glb_store_dma: expected bank lines are queued as words are driven and compared as they appear.
module tb_glb_store_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_st_dma_on;
  logic        hdr_wr_en;
  logic [43:0] hdr_in;
  logic        hdr_full;
  logic [2:0]  hdr_count;
  logic [15:0] stream_data_f2g;
  logic        stream_data_valid_f2g;
  logic [94:0] wr_packet;
  logic        st_dma_done_pulse;
`ifdef GLB_ST_DMA_DROP_CNT_EN
  logic [15:0] st_dma_drop_cnt;
`endif

  logic        pkt_wr_en;
  logic [7:0]  pkt_strb;
  logic [21:0] pkt_addr;
  logic [63:0] pkt_data;
  assign {pkt_wr_en, pkt_strb, pkt_addr, pkt_data} = wr_packet;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  strb;
    logic [63:0] data;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  glb_store_dma #(.QUEUE_DEPTH(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cfg_st_dma_on         (cfg_st_dma_on),
    .hdr_wr_en             (hdr_wr_en),
    .hdr_in                (hdr_in),
    .hdr_full              (hdr_full),
    .hdr_count             (hdr_count),
    .stream_data_f2g       (stream_data_f2g),
    .stream_data_valid_f2g (stream_data_valid_f2g),
    .wr_packet             (wr_packet),
    .st_dma_done_pulse     (st_dma_done_pulse)
`ifdef GLB_ST_DMA_DROP_CNT_EN
    ,
    .st_dma_drop_cnt       (st_dma_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic v, input logic [21:0] addr, input logic [20:0] nw);
    hdr_in    = {v, addr, nw};
    hdr_wr_en = 1'b1;
    tick();
    hdr_wr_en = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    stream_data_f2g       = w;
    stream_data_valid_f2g = 1'b1;
    tick();
    stream_data_valid_f2g = 1'b0;
  endtask

  task automatic expect_line(input logic [21:0] a, input logic [7:0] s, input logic [63:0] d, input logic dn);
    exp_t e;
    e.addr = a; e.strb = s; e.data = d; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
    check(tag, done_cnt, target);
  endtask

  // Scoreboard side: every emitted line must match the oldest expectation.
  always @(negedge clk) begin
    if (st_dma_done_pulse) done_cnt++;
    if (pkt_wr_en) begin
      if (sb.size() == 0) begin
        check("wr_without_expect", pkt_wr_en, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", pkt_addr, e.addr);
        check("wr_strb", pkt_strb, e.strb);
        check("wr_data", pkt_data, e.data);
        check("done_with_line", st_dma_done_pulse, e.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_st_dma_on = 1'b0; hdr_wr_en = 1'b0; hdr_in = '0;
    stream_data_f2g = '0; stream_data_valid_f2g = 1'b0;
    tick(); tick();
    check("rst_hdr_full", hdr_full, 1'b0);
    check("rst_hdr_count", hdr_count, 3'd0);
    check("rst_wr_packet", wr_packet, 95'd0);
    check("rst_done", st_dma_done_pulse, 1'b0);
    reset = 1'b0;
    tick();

    // Aligned 8-word transfer: two full lines.
    cfg_st_dma_on = 1'b1;
    push_hdr(1'b1, 22'h000040, 21'd8);
    tick();
    check("pop_aligned", hdr_count, 3'd0);
    expect_line(22'h000040, 8'hFF, 64'h0004_0003_0002_0001, 1'b0);
    expect_line(22'h000048, 8'hFF, 64'h0008_0007_0006_0005, 1'b1);
    for (int i = 1; i <= 8; i++) send_word(16'(i));
    exp_done++;
    wait_done("aligned_done", exp_done, 10);
    tick(); tick();

    // Unaligned 3-word transfer starting in lane 3.
    push_hdr(1'b1, 22'h000106, 21'd3);
    tick();
    expect_line(22'h000100, 8'hC0, 64'hAAAA_0000_0000_0000, 1'b0);
    expect_line(22'h000108, 8'h0F, 64'h0000_0000_CCCC_BBBB, 1'b1);
    send_word(16'hAAAA);
    send_word(16'hBBBB);
    send_word(16'hCCCC);
    exp_done++;
    wait_done("unaligned_done", exp_done, 10);
    tick(); tick();

    // Fill the FIFO with zero-word headers while popping is disabled; the 5th push is ignored.
    cfg_st_dma_on = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hdr_in    = {1'b1, 22'(i * 8), 21'd0};
      hdr_wr_en = 1'b1;
      tick();
      if (i == 3) begin
        check("full_after_4", hdr_full, 1'b1);
        check("count_after_4", hdr_count, 3'd4);
      end
    end
    hdr_wr_en = 1'b0;
    check("full_after_5", hdr_full, 1'b1);
    check("count_after_5", hdr_count, 3'd4);
    cfg_st_dma_on = 1'b1;
    exp_done += 4;
    wait_done("drain_done", exp_done, 30);
    tick(); tick();
    check("drained_count", hdr_count, 3'd0);

    // Zero-word header: pulse right after the pop, no write.
    push_hdr(1'b1, 22'h000200, 21'd0);
    check("zw_pop_cycle_count", hdr_count, 3'd1);
    check("zw_pop_cycle_done", st_dma_done_pulse, 1'b0);
    tick();
    exp_done++;
    check("zw_count", hdr_count, 3'd0);
    check("zw_done", st_dma_done_pulse, 1'b1);
    tick();
    check("zw_done_one_cycle", st_dma_done_pulse, 1'b0);
    tick();

    // Invalid header: popped and discarded silently.
    push_hdr(1'b0, 22'h000200, 21'd5);
    tick(); tick(); tick();
    check("inv_count", hdr_count, 3'd0);
    check("inv_no_done", done_cnt, exp_done);

    // Reset after 2 of 4 words: the partial line is discarded.
    push_hdr(1'b1, 22'h000300, 21'd4);
    tick();
    send_word(16'h1111);
    send_word(16'h2222);
    reset = 1'b1;
    #1;
    check("midrst_wr_packet", wr_packet, 95'd0);
    check("midrst_done", st_dma_done_pulse, 1'b0);
    check("midrst_count", hdr_count, 3'd0);
    tick();
    reset = 1'b0;
    tick();

    // Words with no active transfer are dropped.
    for (int i = 0; i < 5; i++) send_word(16'h5000 + 16'(i));
    tick(); tick();
    check("idle_no_wr", wr_packet, 95'd0);
`ifdef GLB_ST_DMA_DROP_CNT_EN
    check("drop_cnt", st_dma_drop_cnt, 16'd5);
`endif

    tick(); tick();
    check("sb_empty", sb.size(), 0);
    check("total_done", done_cnt, exp_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
